// File: rtl/qec_frame_sequencer.sv
// Frame sequencer for the Helios decoder byte stream: START once per reset, then per frame
// HEADER + measurement payload (+ erasure payload when QEC_SEQ_ERASURE_EN is defined) and result parsing.
module qec_frame_sequencer #(
  parameter int                    DATA_WIDTH         = 8,
  parameter int                    BYTES_PER_ROUND    = 38,
  parameter int                    MEASUREMENT_ROUNDS = 19,
  parameter int                    ERASURE_BYTES      = 0,
  parameter logic [DATA_WIDTH-1:0] START_MSG          = 'hFF,
  parameter logic [DATA_WIDTH-1:0] HEADER_MSG         = 'h01,
  parameter int                    RESULT_BYTES       = 3,
  parameter int                    TIMEOUT_CYCLES     = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] dec_in_data,
  output logic                  dec_in_valid,
  input  logic                  dec_in_ready,
  input  logic [DATA_WIDTH-1:0] dec_out_data,
  input  logic                  dec_out_valid,
  output logic                  dec_out_ready,
  output logic [7:0]            res_iterations,
  output logic [15:0]           res_cycles,
  output logic [15:0]           res_frame_id,
  output logic                  res_timeout,
  output logic                  res_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int MEAS_BYTES = BYTES_PER_ROUND * MEASUREMENT_ROUNDS;
  localparam int CNT_W      = $clog2(MEAS_BYTES + ERASURE_BYTES + 1);
  localparam int RX_W       = (RESULT_BYTES < 3) ? 2 : $clog2(RESULT_BYTES + 1);
`ifdef QEC_SEQ_ERASURE_EN
  localparam int ERAS_BYTES = ERASURE_BYTES;
`endif

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_HEADER   = 3'd1,
    ST_MEAS     = 3'd2,
`ifdef QEC_SEQ_ERASURE_EN
    ST_ERAS     = 3'd3,
`endif
    ST_WAIT_RES = 3'd4,
    ST_COLLECT  = 3'd5,
    ST_EMIT     = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_armed;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [RX_W-1:0]  r_rx_cnt;
  logic [31:0]      r_tmo_cnt;
  logic [7:0]       r_res_iterations;
  logic [15:0]      r_res_cycles;
  logic [15:0]      r_frame_id;
  logic             r_res_timeout;
  logic             r_res_overflow;

  logic [CNT_W-1:0] w_byte_cnt_inc;
  logic             w_pl_xfer;
  logic             w_tmo_hit;
  logic             w_rx_done;

  assign w_byte_cnt_inc = r_byte_cnt + CNT_W'(1);
  assign w_pl_xfer      = pl_valid && dec_in_ready;
  assign w_tmo_hit      = (TIMEOUT_CYCLES != 0) && ((r_tmo_cnt + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign w_rx_done      = (r_rx_cnt >= RX_W'(RESULT_BYTES));

  assign res_iterations = r_res_iterations;
  assign res_cycles     = r_res_cycles;
  assign res_frame_id   = r_frame_id;
  assign res_timeout    = r_res_timeout;
  assign res_overflow   = r_res_overflow;

  always_comb begin
    w_state_next  = r_state;
    dec_in_data   = '0;
    dec_in_valid  = 1'b0;
    pl_ready      = 1'b0;
    dec_out_ready = 1'b0;
    res_valid     = 1'b0;
    busy          = 1'b1;
    case (r_state)
      ST_START: begin
        // r_armed holds START quiet for the first cycle so nothing is offered while in reset
        busy         = 1'b0;
        dec_in_data  = START_MSG;
        dec_in_valid = r_armed;
        if (r_armed && dec_in_ready) w_state_next = ST_HEADER;
      end
      ST_HEADER: begin
        dec_in_data  = HEADER_MSG;
        dec_in_valid = 1'b1;
        if (dec_in_ready) w_state_next = ST_MEAS;
      end
      ST_MEAS: begin
        dec_in_data  = pl_data;
        dec_in_valid = pl_valid;
        pl_ready     = dec_in_ready;
        if (w_pl_xfer && (w_byte_cnt_inc == CNT_W'(MEAS_BYTES))) begin
`ifdef QEC_SEQ_ERASURE_EN
          w_state_next = (ERAS_BYTES != 0) ? ST_ERAS : ST_WAIT_RES;
`else
          w_state_next = ST_WAIT_RES;
`endif
        end
      end
`ifdef QEC_SEQ_ERASURE_EN
      ST_ERAS: begin
        dec_in_data  = pl_data;
        dec_in_valid = pl_valid;
        pl_ready     = dec_in_ready;
        if (w_pl_xfer && (w_byte_cnt_inc == CNT_W'(MEAS_BYTES + ERAS_BYTES)))
          w_state_next = ST_WAIT_RES;
      end
`endif
      ST_WAIT_RES: begin
        dec_out_ready = 1'b1;
        if (w_tmo_hit)          w_state_next = ST_EMIT;
        else if (dec_out_valid) w_state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        dec_out_ready = 1'b1;
        if (w_tmo_hit || (!dec_out_valid && w_rx_done)) w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = ST_HEADER;
      end
      default: w_state_next = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_START;
      r_armed          <= 1'b0;
      r_byte_cnt       <= '0;
      r_rx_cnt         <= '0;
      r_tmo_cnt        <= '0;
      r_res_iterations <= '0;
      r_res_cycles     <= '0;
      r_frame_id       <= '0;
      r_res_timeout    <= 1'b0;
      r_res_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
      case (r_state)
        ST_HEADER: begin
          if (dec_in_ready) begin
            r_byte_cnt <= '0;
            r_tmo_cnt  <= '0;
          end
        end
`ifdef QEC_SEQ_ERASURE_EN
        ST_MEAS, ST_ERAS: begin
`else
        ST_MEAS: begin
`endif
          if (w_pl_xfer) r_byte_cnt <= w_byte_cnt_inc;
        end
        ST_WAIT_RES, ST_COLLECT: begin
          // A timeout discards any partially received message
          if (w_tmo_hit) begin
            r_res_timeout    <= 1'b1;
            r_res_iterations <= '0;
            r_res_cycles     <= '0;
            r_res_overflow   <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
            if (dec_out_valid) begin
              if (r_state == ST_WAIT_RES) begin
                r_res_iterations <= dec_out_data[7:0];
                r_rx_cnt         <= RX_W'(1);
              end else if (!w_rx_done) begin
                if (r_rx_cnt == RX_W'(1))      r_res_cycles[15:8] <= dec_out_data[7:0];
                else if (r_rx_cnt == RX_W'(2)) r_res_cycles[7:0]  <= dec_out_data[7:0];
                r_rx_cnt <= r_rx_cnt + RX_W'(1);
              end else begin
                r_res_overflow <= 1'b1;
              end
            end
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            r_frame_id       <= r_frame_id + 16'd1;
            r_res_timeout    <= 1'b0;
            r_res_overflow   <= 1'b0;
            r_res_iterations <= '0;
            r_res_cycles     <= '0;
            r_rx_cnt         <= '0;
            r_tmo_cnt        <= '0;
            r_byte_cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qec_frame_sequencer.sv
// Directed self-checking bench for qec_frame_sequencer: START/HEADER injection, stalled payload
// passthrough, result parsing, overflow, timeout and mid-frame reset.
module tb_qec_frame_sequencer;

  localparam int BPR   = 2;
  localparam int ROUNDS = 3;
  localparam int ERAS  = 4;
`ifdef QEC_SEQ_ERASURE_EN
  localparam int PAYLOAD = BPR * ROUNDS + ERAS;
`else
  localparam int PAYLOAD = BPR * ROUNDS;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  dec_in_data;
  logic        dec_in_valid;
  logic        dec_in_ready;
  logic [7:0]  dec_out_data;
  logic        dec_out_valid;
  logic        dec_out_ready;
  logic [7:0]  res_iterations;
  logic [15:0] res_cycles;
  logic [15:0] res_frame_id;
  logic        res_timeout;
  logic        res_overflow;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  qec_frame_sequencer #(
    .DATA_WIDTH(8), .BYTES_PER_ROUND(BPR), .MEASUREMENT_ROUNDS(ROUNDS),
    .ERASURE_BYTES(ERAS), .START_MSG(8'hFF), .HEADER_MSG(8'h01),
    .RESULT_BYTES(3), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .dec_in_data(dec_in_data), .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready),
    .dec_out_data(dec_out_data), .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready),
    .res_iterations(res_iterations), .res_cycles(res_cycles), .res_frame_id(res_frame_id),
    .res_timeout(res_timeout), .res_overflow(res_overflow), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one control byte from the sequencer and accept it at the next rising edge
  task automatic send_ctrl(input string tag, input logic [7:0] exp_byte, input logic exp_busy);
    @(negedge clk);
    dec_in_ready = 1'b1;
    pl_valid     = 1'b0;
    res_ready    = 1'b0;
    #1;
    check_val({tag, "_valid"}, 32'(dec_in_valid), 32'd1);
    check_val({tag, "_data"}, 32'(dec_in_data), 32'(exp_byte));
    check_val({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    $display("ctrl %s byte=0x%0h", tag, dec_in_data);
  endtask

  // Push n payload bytes 0xA0+i; stall patterns gate pl_valid and dec_in_ready
  task automatic send_payload(input int n, input logic [7:0] vpat, input logic [7:0] rpat);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 80) begin
      @(negedge clk);
      pl_valid     = vpat[cyc % 8];
      dec_in_ready = rpat[cyc % 8];
      pl_data      = 8'hA0 + 8'(idx);
      #1;
      check_val("pl_ready_pass", 32'(pl_ready), 32'(dec_in_ready));
      if (pl_valid && dec_in_ready) begin
        check_val("fwd_data", 32'(dec_in_data), 32'(8'hA0 + 8'(idx)));
        check_val("fwd_valid", 32'(dec_in_valid), 32'd1);
        idx++;
      end
      cyc++;
    end
    check_val("payload_count", 32'(idx), 32'(n));
    $display("payload %0d bytes in %0d cycles", idx, cyc);
  endtask

  task automatic dec_send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input int n);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pl_valid      = 1'b0;
      dec_out_valid = 1'b1;
      dec_out_data  = bytes[i];
      #1;
      check_val("dec_out_ready", 32'(dec_out_ready), 32'd1);
    end
    @(negedge clk);
    dec_out_valid = 1'b0;
  endtask

  task automatic check_result(input logic [7:0] it, input logic [15:0] cy, input logic [15:0] fid,
                              input logic tmo, input logic ovf);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check_val("res_valid", 32'(res_valid), 32'd1);
    check_val("res_iterations", 32'(res_iterations), 32'(it));
    check_val("res_cycles", 32'(res_cycles), 32'(cy));
    check_val("res_frame_id", 32'(res_frame_id), 32'(fid));
    check_val("res_timeout", 32'(res_timeout), 32'(tmo));
    check_val("res_overflow", 32'(res_overflow), 32'(ovf));
    $display("result it=%0d cycles=%0d frame=%0d tmo=%0d ovf=%0d",
             res_iterations, res_cycles, res_frame_id, res_timeout, res_overflow);
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check_val("res_hold_valid", 32'(res_valid), 32'd1);
    check_val("res_hold_cycles", 32'(res_cycles), 32'(cy));
  endtask

  initial begin
    int wait_n;
    reset = 1'b0; pl_data = '0; pl_valid = 1'b0; dec_in_ready = 1'b0;
    dec_out_data = '0; dec_out_valid = 1'b0; res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    dec_in_ready = 1'b1; pl_valid = 1'b1; dec_out_valid = 1'b1;
    #1;
    check_val("rst_dec_in_valid", 32'(dec_in_valid), 32'd0);
    check_val("rst_pl_ready", 32'(pl_ready), 32'd0);
    check_val("rst_dec_out_ready", 32'(dec_out_ready), 32'd0);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fields", {res_iterations, res_cycles[7:0], res_frame_id[7:0], 6'd0, res_timeout, res_overflow}, 32'd0);
    pl_valid = 1'b0; dec_out_valid = 1'b0; dec_in_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Frame 0: stalled payload, normal 3-byte result
    send_ctrl("start", 8'hFF, 1'b0);
    send_ctrl("hdr0", 8'h01, 1'b1);
    send_payload(PAYLOAD, 8'b1011_0111, 8'b1101_1011);
    @(negedge clk);
    pl_valid = 1'b1; dec_in_ready = 1'b1;
    #1;
    check_val("post_pl_ready", 32'(pl_ready), 32'd0);
    check_val("post_dec_in_valid", 32'(dec_in_valid), 32'd0);
    check_val("wait_dec_out_ready", 32'(dec_out_ready), 32'd1);
    dec_send(8'h05, 8'h01, 8'h2C, 8'h00, 3);
    check_result(8'd5, 16'd300, 16'd0, 1'b0, 1'b0);

    // Frame 1: 4-byte result, last byte accepted and dropped
    send_ctrl("hdr1", 8'h01, 1'b1);
    check_val("hdr1_res_valid", 32'(res_valid), 32'd0);
    send_payload(PAYLOAD, 8'hFF, 8'hFF);
    dec_send(8'h02, 8'h00, 8'h10, 8'h77, 4);
    check_result(8'd2, 16'd16, 16'd1, 1'b0, 1'b1);

    // Frame 2: no decoder response, timeout 100 cycles after WAIT_RES entry
    send_ctrl("hdr2", 8'h01, 1'b1);
    send_payload(PAYLOAD, 8'hFF, 8'hFF);
    wait_n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      pl_valid = 1'b0;
      #1;
      if (res_valid) break;
      wait_n++;
    end
    check_val("timeout_latency", 32'(wait_n), 32'd100);
    check_result(8'd0, 16'd0, 16'd2, 1'b1, 1'b0);
    send_ctrl("hdr3", 8'h01, 1'b1);

    // Frame 3: reset pulsed mid-payload
    send_payload(3, 8'hFF, 8'hFF);
    @(negedge clk);
    reset = 1'b0; pl_valid = 1'b1;
    #1;
    check_val("midrst_res_valid", 32'(res_valid), 32'd0);
    check_val("midrst_dec_in_valid", 32'(dec_in_valid), 32'd0);
    check_val("midrst_pl_ready", 32'(pl_ready), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    pl_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rel_res_valid", 32'(res_valid), 32'd0);
    send_ctrl("restart", 8'hFF, 1'b0);
    check_val("restart_frame_id", 32'(res_frame_id), 32'd0);
    send_ctrl("hdr_after_rst", 8'h01, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
